// File: rtl/pipelined_signed_addsub.sv
// Pipelined signed adder/subtractor: CHUNK-bit ripple slices, one register per slice, skewed operands.
// Optional macro SATURATE_EN clamps SUM on signed overflow in the final slice.
module pipelined_signed_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int STAGES = WIDTH / CHUNK;

  logic advance;

  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;

  // Operand capture: B is inverted and carry-in forced for subtraction here.
  logic             in_v_q;
  logic             in_c_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v_q <= 1'b0;
      in_c_q <= 1'b0;
      in_a_q <= '0;
      in_b_q <= '0;
    end else if (advance) begin
      in_v_q <= in_valid;
      if (in_valid) begin
        in_a_q <= a;
        in_b_q <= sub ? ~b : b;
        in_c_q <= sub | c_in;
      end
    end
  end

  // Slice k consumes the low chunk of what is left of the operands and passes the rest upward.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_slice
    localparam int IW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [IW-1:0]       a_i;
    logic [IW-1:0]       b_i;
    logic                v_i;
    logic                c_i;
    logic [CHUNK:0]      part;
    logic [SW-1:0]       s_next;
    logic                v_q;
    logic                c_q;
    logic [IW-CHUNK-1:0] a_q;
    logic [IW-CHUNK-1:0] b_q;
    logic [SW-1:0]       s_q;

    if (k == 0) begin : g_src
      assign a_i    = in_a_q;
      assign b_i    = in_b_q;
      assign v_i    = in_v_q;
      assign c_i    = in_c_q;
      assign s_next = part[CHUNK-1:0];
    end else begin : g_src
      assign a_i    = g_slice[k-1].a_q;
      assign b_i    = g_slice[k-1].b_q;
      assign v_i    = g_slice[k-1].v_q;
      assign c_i    = g_slice[k-1].c_q;
      assign s_next = {part[CHUNK-1:0], g_slice[k-1].s_q};
    end

    assign part = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_i;
        c_q <= part[CHUNK];
        a_q <= a_i[IW-1:CHUNK];
        b_q <= b_i[IW-1:CHUNK];
        s_q <= s_next;
      end
    end
  end

  logic [CHUNK-1:0] a_l;
  logic [CHUNK-1:0] b_l;
  logic             v_l;
  logic             c_l;
  logic [CHUNK:0]   part_l;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sum_l;
  logic             ovf_l;

  if (STAGES == 1) begin : g_last
    assign a_l     = in_a_q;
    assign b_l     = in_b_q;
    assign v_l     = in_v_q;
    assign c_l     = in_c_q;
    assign raw_sum = part_l[CHUNK-1:0];
  end else begin : g_last
    assign a_l     = g_slice[STAGES-2].a_q;
    assign b_l     = g_slice[STAGES-2].b_q;
    assign v_l     = g_slice[STAGES-2].v_q;
    assign c_l     = g_slice[STAGES-2].c_q;
    assign raw_sum = {part_l[CHUNK-1:0], g_slice[STAGES-2].s_q};
  end

  assign part_l = {1'b0, a_l} + {1'b0, b_l} + {{CHUNK{1'b0}}, c_l};
  assign ovf_l  = (a_l[CHUNK-1] == b_l[CHUNK-1]) && (part_l[CHUNK-1] != a_l[CHUNK-1]);

`ifdef SATURATE_EN
  // Clamp direction follows the sign of A, which equals the sign of the true result on overflow.
  assign sum_l = !ovf_l ? raw_sum :
                 a_l[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_l = raw_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (advance) begin
      out_valid <= v_l;
      if (v_l) begin
        sum      <= sum_l;
        carry    <= part_l[CHUNK];
        overflow <= ovf_l;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && overflow) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_signed_addsub.sv
// Directed bench for pipelined_signed_addsub (WIDTH=16, CHUNK=4): hand-computed vectors,
// in-order scoreboard, latency, back-to-back, stall, reset flush and sticky overflow behaviour.
module tb_pipelined_signed_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry;
  logic        overflow;
  logic        ovf_sticky;
  logic        ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  int cyc      = 0;

  logic [17:0] exp_q[$];
  int          pop_cyc[$];
  logic [17:0] mon_e;

  // Hand-computed vectors: a, b, sub, c_in -> wrapped sum, clamped sum, carry, overflow.
  localparam logic [15:0] VA [14] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h0005, 16'h0007, 16'h8000,
                                      16'h4000, 16'h00FF, 16'h0FFF, 16'h8000, 16'h0000, 16'h1234, 16'h7FFF};
  localparam logic [15:0] VB [14] = '{16'h0001, 16'h0001, 16'h0001, 16'h0F0F, 16'h0007, 16'h0005, 16'h8000,
                                      16'h4000, 16'h0001, 16'h0000, 16'h8000, 16'h0001, 16'h1234, 16'hFFFF};
  localparam logic        VS [14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic        VC [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [15:0] VSUM [14] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h2144, 16'hFFFE, 16'h0002, 16'h0000,
                                        16'h8000, 16'h0100, 16'h1000, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000};
  localparam logic [15:0] VSAT [14] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h2144, 16'hFFFE, 16'h0002, 16'h8000,
                                        16'h7FFF, 16'h0100, 16'h1000, 16'h0000, 16'hFFFF, 16'h0000, 16'h7FFF};
  localparam logic        VCY [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic        VO  [14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  pipelined_signed_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [15:0] exp_sum(input int idx);
`ifdef SATURATE_EN
    return VSAT[idx];
`else
    return VSUM[idx];
`endif
  endfunction

  // Scoreboard: every handshaken result must match the oldest accepted beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(sum), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(mon_e[15:0]));
        check("carry", 32'(carry), 32'(mon_e[16]));
        check("overflow", 32'(overflow), 32'(mon_e[17]));
        pop_cyc.push_back(cyc);
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    c_in     = 1'b0;
  endtask

  task automatic send(input int idx);
    bit acc = 1'b0;
    a        = VA[idx];
    b        = VB[idx];
    sub      = VS[idx];
    c_in     = VC[idx];
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", 32'(acc), 32'd1);
    if (acc) exp_q.push_back({VO[idx], VCY[idx], exp_sum(idx)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p5 [8] = '{10, 11, 12, 13, 0, 1, 4, 5};
    int consec;
    int pop_start;
    int seen;
    logic [15:0] held_sum;
    logic        held_carry;

    rst       = 1'b1;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    idle();
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sticky", 32'(ovf_sticky), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single beat: latency and sticky set/clear.
    send(0);
    idle();
    repeat (3) tick();
    check("lat_early", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("sticky_before_hs", 32'(ovf_sticky), 32'd0);
    tick();
    check("sticky_set", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    tick();
    check("sticky_clr", 32'(ovf_sticky), 32'd0);
    ovf_clr = 1'b0;

    // Back-to-back stream.
    pop_cyc.delete();
    for (int i = 2; i <= 9; i++) send(i);
    idle();
    repeat (8) tick();
    check("b2b_results", 32'(pop_cyc.size()), 32'd8);
    consec = 0;
    for (int i = 1; i < pop_cyc.size(); i++)
      if (pop_cyc[i] - pop_cyc[i-1] == 1) consec++;
    check("b2b_consecutive", 32'(consec), 32'd7);

    // Three-cycle downstream stall mid-stream.
    pop_start = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) send(p5[i]);
        idle();
      end
      begin
        repeat (6) tick();
        check("stall_pre_valid", 32'(out_valid), 32'd1);
        out_ready  = 1'b0;
        held_sum   = sum;
        held_carry = carry;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          check("stall_sum_hold", 32'(sum), 32'(held_sum));
          check("stall_carry_hold", 32'(carry), 32'(held_carry));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) tick();
    check("stall_result_count", 32'(n_pop - pop_start), 32'd8);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset with beats in flight.
    send(3);
    send(2);
    send(4);
    send(5);
    send(8);
    idle();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_sum", 32'(sum), 32'd0);
    check("flush_carry", 32'(carry), 32'd0);
    check("flush_overflow", 32'(overflow), 32'd0);
    check("flush_sticky", 32'(ovf_sticky), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_beat", 32'(seen), 32'd0);
    tick();

    // Set and clear in the same cycle: set wins; clear alone next cycle.
    send(0);
    idle();
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("setclr_valid", 32'(seen), 32'd1);
    ovf_clr = 1'b1;
    tick();
    check("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    tick();
    check("sticky_clr_alone", 32'(ovf_sticky), 32'd0);
    ovf_clr = 1'b0;
    repeat (2) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
